btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
Input conditioning stage directly upstream of code_FSM. It synchronises, debounces and edge-detects the four raw Basys 3 push-buttons (U, D, L, R). It emits exactly one single-cycle pulse per accepted press on the Ubtn/Dbtn/Lbtn/Rbtn lines that code_FSM consumes. It also resolves simultaneous and overlapping presses so the code FSM never sees two keys in one entry.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable-level cycles required to accept a press or release (10 ms at 100 MHz); must be >= 1; simulation uses 4
CNT_WIDTH, 20, debounce counter width; DEBOUNCE_CYCLES-1 must fit in CNT_WIDTH bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Ubtn_raw  in  1  raw up button, asynchronous, active-high
Dbtn_raw  in  1  raw down button
Lbtn_raw  in  1  raw left button
Rbtn_raw  in  1  raw right button
Ubtn  out  1  one-cycle accepted-press pulse to code_FSM
Dbtn  out  1  one-cycle pulse
Lbtn  out  1  one-cycle pulse
Rbtn  out  1  one-cycle pulse
key_valid  out  1  OR of the four pulses, same cycle
key_code  out  2  last accepted key: U=0, D=1, L=2, R=3; held until next accept
btn_level  out  4  debounced levels {U,D,L,R}, bit3=U

Behaviour:
- Reset (reset=0) is asynchronous. While reset is low, all of the following are 0: synchroniser flops, counters, channel states, pulses, key_valid, key_code and btn_level.
- Synchroniser: two flops per raw input; s2 is the synchronised level.
- Per-channel FSM, four independent instances. cnt clears on every state change.
  - IDLE (level 0): s2=1 -> PRESS_WAIT.
  - PRESS_WAIT: s2=0 -> IDLE. s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, raising a press request. Otherwise cnt++.
  - PRESSED (level 1): s2=0 -> RELEASE_WAIT.
  - RELEASE_WAIT (level stays 1): s2=1 -> PRESSED, with no new request. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE (level 0). Otherwise cnt++.
- Latency: with raw held high from edge 1 (the first edge that samples it), the pulse and the btn_level bit are registered high at edge DEBOUNCE_CYCLES+3. Release is symmetric: btn_level drops at edge DEBOUNCE_CYCLES+3 after raw goes low.
- Arbitration, registered, evaluated in the cycle a request is raised:
  - Lockout: a request is discarded if any other channel's btn_level is 1 in that cycle. While one key is held, other keys are ignored.
  - Simultaneous requests: priority U > D > L > R. Only the winner pulses; losers are discarded permanently (no deferred pulse). The loser channel still goes to PRESSED, so its level reads 1 and it must be released and re-pressed to produce a pulse.
- Output on an accepted request: exactly one of Ubtn/Dbtn/Lbtn/Rbtn is high for one cycle, key_valid is high in the same cycle, and key_code updates on the same edge.
- A held button never repeats. A further pulse requires reaching IDLE and re-pressing.
- Reset asserted mid-debounce aborts with no pulse. If a button is still held after reset release, it is re-detected as a fresh press at edge DEBOUNCE_CYCLES+3 after release.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and a 20 ns clock.
1. Reset: reset=0 for 100 ns with all raw buttons toggling -> all outputs 0 throughout; all outputs still 0 after release with buttons at 0.
2. Clean press: Ubtn_raw high for 20 cycles, then low for 10 -> single Ubtn pulse at edge 7, key_valid=1 in the same cycle, key_code=0, btn_level=4'b1000 until 7 edges after release.
3. Press bounce: Lbtn_raw toggles every 2 cycles for 12 cycles, then is steady high -> no pulse during bouncing; exactly one Lbtn pulse 7 edges after the steady level begins; key_code=2.
4. Release bounce: Rbtn held, released, then a 1-cycle high glitch 2 cycles into release -> no second Rbtn pulse; after a full release, a re-press yields a second pulse, key_code=3.
5. Conflicts: Dbtn_raw and Rbtn_raw rise on the same edge -> only Dbtn pulses, key_code=1, btn_level=4'b0101. Separately, hold Ubtn_raw and then press Lbtn_raw -> no Lbtn pulse.
6. Reset mid-press: Ubtn_raw high, reset=0 at edge 5, released at edge 8 with the button still held -> no pulse before edge 8; one Ubtn pulse 7 edges after reset release.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button front end for code_FSM: two-flop synchroniser, per-button debounce FSM,
// and one-hot arbitration that turns each accepted press into a single pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ubtn_raw,
  input  logic       Dbtn_raw,
  input  logic       Lbtn_raw,
  input  logic       Rbtn_raw,
  output logic       Ubtn,
  output logic       Dbtn,
  output logic       Lbtn,
  output logic       Rbtn,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic [3:0] btn_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } chan_state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Channel index i maps to btn_level bit i: 3=U, 2=D, 1=L, 0=R.
  logic [3:0]           raw;
  logic [3:0]           sync1_q, sync2_q;
  chan_state_e          state_q [4];
  chan_state_e          state_d [4];
  logic [CNT_WIDTH-1:0] cnt_q   [4];
  logic [CNT_WIDTH-1:0] cnt_d   [4];
  logic [3:0]           req;
  logic [3:0]           level;
  logic [3:0]           lockout;
  logic [3:0]           accepted;
  logic [3:0]           pulse_q, pulse_d;
  logic [1:0]           key_code_q, key_code_d;

  assign raw = {Ubtn_raw, Dbtn_raw, Lbtn_raw, Rbtn_raw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // The counter only runs while waiting; every transition lands with it cleared.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) state_d[i] = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!sync2_q[i])             state_d[i] = IDLE;
          else if (cnt_q[i] == CntMax) state_d[i] = PRESSED;
          else                         cnt_d[i]   = cnt_q[i] + 1'b1;
        end
        PRESSED: begin
          if (!sync2_q[i]) state_d[i] = RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (sync2_q[i])              state_d[i] = PRESSED;
          else if (cnt_q[i] == CntMax) state_d[i] = IDLE;
          else                         cnt_d[i]   = cnt_q[i] + 1'b1;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    req   = '0;
    level = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]   = (state_q[i] == PRESS_WAIT) && sync2_q[i] && (cnt_q[i] == CntMax);
      level[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
    end
  end

  // Losers and locked-out requests are dropped outright; the ascending loop lets U win.
  always_comb begin
    lockout    = '0;
    accepted   = '0;
    pulse_d    = '0;
    key_code_d = key_code_q;
    for (int i = 0; i < 4; i++) begin
      lockout[i]  = |(level & ~(4'(1) << i));
      accepted[i] = req[i] & ~lockout[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (accepted[i]) begin
        pulse_d    = 4'(1) << i;
        key_code_d = 2'(3 - i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q    <= '0;
      key_code_q <= '0;
    end else begin
      pulse_q    <= pulse_d;
      key_code_q <= key_code_d;
    end
  end

  assign Ubtn      = pulse_q[3];
  assign Dbtn      = pulse_q[2];
  assign Lbtn      = pulse_q[1];
  assign Rbtn      = pulse_q[0];
  assign key_valid = |pulse_q;
  assign key_code  = key_code_q;
  assign btn_level = level;

endmodule
